// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the PC and fetches from variable-latency instruction memory
//            into a single-entry decode slot, with redirect and hlt parking.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst_out,
    output logic [15:0] inst_pc,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [15:0] c_PC_STEP = 16'd2;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_inst_valid;
    logic [15:0] r_inst_out;
    logic [15:0] r_inst_pc;
    logic        r_halted;

    logic        w_req;
    logic        w_accept;
    logic        w_consume;

    // A full slot that decode is holding blocks new requests; redirect kills any request.
    assign w_req     = (r_state == FETCH) & ~redirect & (~r_inst_valid | ~stall);
    assign w_accept  = w_req & imem_ready;
    assign w_consume = r_inst_valid & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_out   <= 16'h0000;
            r_inst_pc    <= 16'h0000;
            r_halted     <= 1'b0;
        end else if (redirect) begin
            r_state      <= FETCH;
            r_pc         <= {redirect_pc[15:1], 1'b0};
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (w_accept) begin
                        r_inst_out   <= imem_data;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        if (imem_data[15:12] == HLT_OPCODE) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= r_pc + c_PC_STEP;
                        end
                    end else if (w_consume) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                HALT: begin
                    // The hlt word drains to decode; pc stays parked on it.
                    if (w_consume) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst_out   = r_inst_out;
    assign inst_pc    = r_inst_pc;
    assign halted     = r_halted;

endmodule
`default_nettype wire
